// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: sequences the IF PC and the IF/ID register around memory
// latency, pipeline stalls and branch/jump/exception redirects.
module fetch_ctrl #(
   parameter logic [31:0] RESET_VEC = 32'h0000_0000,
   parameter logic [31:0] EXC_VEC   = 32'h0000_0004,
   parameter int unsigned TIMEOUT   = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        STALL,
   input  logic        BR_TAKEN,
   input  logic [31:0] BR_TARGET,
   input  logic        JMP_VALID,
   input  logic [31:0] JMP_TARGET,
   input  logic        EXC_VALID,
   input  logic        IMEM_READY,
   output logic        PC_SRC,
   output logic [31:0] PC_IN,
   output logic        PC_EN,
   output logic        IMEM_REQ,
   output logic        IF_ID_EN,
   output logic        IF_ID_FLUSH,
   output logic        FETCH_ERR,
   output logic [1:0]  STATE
);

   typedef enum logic [1:0] {
      StBoot  = 2'b00,
      StFetch = 2'b01,
      StWait  = 2'b10,
      StHold  = 2'b11
   } state_e;

   localparam logic [1:0] PriNone = 2'd0;
   localparam logic [1:0] PriJmp  = 2'd1;
   localparam logic [1:0] PriBr   = 2'd2;
   localparam logic [1:0] PriExc  = 2'd3;

   // The WAIT cycle whose increment would reach TIMEOUT-1 is the timeout cycle, so the
   // FETCH cycle plus TIMEOUT-1 WAIT cycles make TIMEOUT not-ready cycles in total.
   localparam logic [7:0] WcntLast = 8'(TIMEOUT - 2);

   state_e      state_q, state_d;
   logic        pend_v_q, pend_v_d;
   logic [1:0]  pend_pri_q, pend_pri_d;
   logic [31:0] pend_tgt_q, pend_tgt_d;
   logic [7:0]  wcnt_q, wcnt_d;

   logic        live_v;
   logic [1:0]  live_pri;
   logic [31:0] live_tgt;
   logic        eff_v;
   logic [31:0] eff_tgt;
   logic        cap_ok;
   logic        do_apply;
   logic        do_capture;

   always_comb begin
      live_v   = EXC_VALID | BR_TAKEN | JMP_VALID;
      live_pri = PriNone;
      live_tgt = 32'h0;
      if (EXC_VALID) begin
         live_pri = PriExc;
         live_tgt = EXC_VEC;
      end else if (BR_TAKEN) begin
         live_pri = PriBr;
         live_tgt = BR_TARGET;
      end else if (JMP_VALID) begin
         live_pri = PriJmp;
         live_tgt = JMP_TARGET;
      end
   end

   // Pending only beats live on strictly higher priority; ties go to the live request.
   always_comb begin
      eff_v   = live_v | pend_v_q;
      eff_tgt = live_tgt;
      if (pend_v_q && (!live_v || (pend_pri_q > live_pri))) begin
         eff_tgt = pend_tgt_q;
      end
      cap_ok = live_v && (!pend_v_q || (live_pri >= pend_pri_q));
   end

   always_comb begin
      state_d     = state_q;
      pend_v_d    = pend_v_q;
      pend_pri_d  = pend_pri_q;
      pend_tgt_d  = pend_tgt_q;
      wcnt_d      = wcnt_q;
      do_apply    = 1'b0;
      do_capture  = 1'b0;
      PC_SRC      = 1'b0;
      PC_IN       = 32'h0;
      PC_EN       = 1'b0;
      IMEM_REQ    = 1'b0;
      IF_ID_EN    = 1'b0;
      IF_ID_FLUSH = 1'b0;
      FETCH_ERR   = 1'b0;

      unique case (state_q)
         StBoot: begin
            PC_SRC      = 1'b1;
            PC_IN       = RESET_VEC;
            PC_EN       = 1'b1;
            IF_ID_FLUSH = 1'b1;
            do_capture  = 1'b1;
            state_d     = StFetch;
         end
         StFetch, StWait: begin
            IMEM_REQ = 1'b1;
            if (IMEM_READY) begin
               if (!STALL || EXC_VALID) begin
                  PC_EN    = 1'b1;
                  IF_ID_EN = 1'b1;
                  do_apply = 1'b1;
                  state_d  = StFetch;
               end else begin
                  do_capture = 1'b1;
                  state_d    = StHold;
               end
            end else if ((state_q == StWait) && (wcnt_q == WcntLast)) begin
               FETCH_ERR  = 1'b1;
               IMEM_REQ   = 1'b0;
               pend_v_d   = 1'b1;
               pend_pri_d = PriExc;
               pend_tgt_d = EXC_VEC;
               state_d    = StFetch;
            end else begin
               do_capture = 1'b1;
               wcnt_d     = (state_q == StFetch) ? 8'd0 : wcnt_q + 8'd1;
               state_d    = StWait;
            end
         end
         StHold: begin
            // No fetch is outstanding here, so an exception can redirect at once.
            if (EXC_VALID) begin
               PC_EN    = 1'b1;
               do_apply = 1'b1;
               state_d  = StFetch;
            end else begin
               do_capture = 1'b1;
               if (!STALL) begin
                  state_d = StFetch;
               end
            end
         end
         default: state_d = StBoot;
      endcase

      if (do_apply && eff_v) begin
         PC_SRC      = 1'b1;
         PC_IN       = eff_tgt;
         IF_ID_FLUSH = 1'b1;
         pend_v_d    = 1'b0;
         pend_pri_d  = PriNone;
         pend_tgt_d  = 32'h0;
      end

      if (do_capture && cap_ok) begin
         pend_v_d   = 1'b1;
         pend_pri_d = live_pri;
         pend_tgt_d = live_tgt;
      end
   end

   assign STATE = state_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= StBoot;
         pend_v_q   <= 1'b0;
         pend_pri_q <= PriNone;
         pend_tgt_q <= 32'h0;
         wcnt_q     <= 8'd0;
      end else begin
         state_q    <= state_d;
         pend_v_q   <= pend_v_d;
         pend_pri_q <= pend_pri_d;
         pend_tgt_q <= pend_tgt_d;
         wcnt_q     <= wcnt_d;
      end
   end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: models the IF PC register and checks control outputs
// against hand-derived vectors per scenario.
module tb_fetch_ctrl;

   logic        clk;
   logic        rst;
   logic        STALL;
   logic        BR_TAKEN;
   logic [31:0] BR_TARGET;
   logic        JMP_VALID;
   logic [31:0] JMP_TARGET;
   logic        EXC_VALID;
   logic        IMEM_READY;
   logic        PC_SRC;
   logic [31:0] PC_IN;
   logic        PC_EN;
   logic        IMEM_REQ;
   logic        IF_ID_EN;
   logic        IF_ID_FLUSH;
   logic        FETCH_ERR;
   logic [1:0]  STATE;

   logic [31:0] pc;
   logic [7:0]  ctl;
   int          n_pass;
   int          n_total;

   // {STATE, PC_SRC, PC_EN, IMEM_REQ, IF_ID_EN, IF_ID_FLUSH, FETCH_ERR}
   localparam logic [7:0] CBoot    = 8'b00110010;
   localparam logic [7:0] CFetAdv  = 8'b01011100;
   localparam logic [7:0] CFetRed  = 8'b01111110;
   localparam logic [7:0] CFetIdle = 8'b01001000;
   localparam logic [7:0] CWait    = 8'b10001000;
   localparam logic [7:0] CWaitErr = 8'b10000001;
   localparam logic [7:0] CWaitRed = 8'b10111110;
   localparam logic [7:0] CHold    = 8'b11000000;
   localparam logic [7:0] CHoldExc = 8'b11110010;

   fetch_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .STALL      (STALL),
      .BR_TAKEN   (BR_TAKEN),
      .BR_TARGET  (BR_TARGET),
      .JMP_VALID  (JMP_VALID),
      .JMP_TARGET (JMP_TARGET),
      .EXC_VALID  (EXC_VALID),
      .IMEM_READY (IMEM_READY),
      .PC_SRC     (PC_SRC),
      .PC_IN      (PC_IN),
      .PC_EN      (PC_EN),
      .IMEM_REQ   (IMEM_REQ),
      .IF_ID_EN   (IF_ID_EN),
      .IF_ID_FLUSH(IF_ID_FLUSH),
      .FETCH_ERR  (FETCH_ERR),
      .STATE      (STATE)
   );

   assign ctl = {STATE, PC_SRC, PC_EN, IMEM_REQ, IF_ID_EN, IF_ID_FLUSH, FETCH_ERR};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // IF-stage PC register as the controller sees it.
   always @(posedge clk) begin
      if (PC_EN) pc <= PC_SRC ? PC_IN : pc + 32'd4;
   end

   // Apply inputs just after the falling edge and let outputs settle.
   task automatic drive(input logic st, input logic br, input logic [31:0] bt,
                        input logic jv, input logic [31:0] jt, input logic ex,
                        input logic rd);
      @(negedge clk);
      STALL = st; BR_TAKEN = br; BR_TARGET = bt; JMP_VALID = jv; JMP_TARGET = jt;
      EXC_VALID = ex; IMEM_READY = rd;
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 1);
      n_total++; if (ctl !== CBoot) $display("FAIL reset_ctl act=%b exp=%b", ctl, CBoot); else n_pass++;
      n_total++; if (PC_IN !== 32'h0) $display("FAIL reset_pcin act=%h exp=%h", PC_IN, 32'h0); else n_pass++;
      drive(0, 1, 32'h100, 0, 0, 1, 1);
      n_total++; if (ctl !== CBoot) $display("FAIL reset_hold_ctl act=%b exp=%b", ctl, CBoot); else n_pass++;
   endtask

   task automatic test_seq;
      @(negedge clk);
      rst = 1'b1; EXC_VALID = 1'b0; BR_TAKEN = 1'b0; IMEM_READY = 1'b1;
      #1;
      n_total++; if (ctl !== CBoot) $display("FAIL seq_boot act=%b exp=%b", ctl, CBoot); else n_pass++;
      for (int i = 0; i < 4; i++) begin
         drive(0, 0, 0, 0, 0, 0, 1);
         n_total++; if (ctl !== CFetAdv) $display("FAIL seq_ctl[%0d] act=%b exp=%b", i, ctl, CFetAdv); else n_pass++;
         n_total++; if (pc !== 32'(4 * i)) $display("FAIL seq_pc[%0d] act=%h exp=%h", i, pc, 32'(4 * i)); else n_pass++;
      end
   endtask

   task automatic test_branch;
      drive(0, 1, 32'h100, 0, 0, 0, 1);
      n_total++; if (ctl !== CFetRed) $display("FAIL br_ctl act=%b exp=%b", ctl, CFetRed); else n_pass++;
      n_total++; if (PC_IN !== 32'h100) $display("FAIL br_pcin act=%h exp=%h", PC_IN, 32'h100); else n_pass++;
      drive(0, 0, 0, 0, 0, 0, 1);
      n_total++; if (ctl !== CFetAdv) $display("FAIL br_after_ctl act=%b exp=%b", ctl, CFetAdv); else n_pass++;
      n_total++; if (pc !== 32'h100) $display("FAIL br_pc act=%h exp=%h", pc, 32'h100); else n_pass++;
   endtask

   task automatic test_priority;
      drive(0, 1, 32'h100, 1, 32'h200, 0, 1);
      n_total++; if (PC_IN !== 32'h100) $display("FAIL pri_br_jmp act=%h exp=%h", PC_IN, 32'h100); else n_pass++;
      drive(0, 1, 32'h100, 1, 32'h200, 1, 1);
      n_total++; if (PC_IN !== 32'h4) $display("FAIL pri_exc act=%h exp=%h", PC_IN, 32'h4); else n_pass++;
      drive(0, 0, 0, 0, 0, 0, 1);
      n_total++; if (pc !== 32'h4) $display("FAIL pri_pc act=%h exp=%h", pc, 32'h4); else n_pass++;
   endtask

   task automatic test_wait_jmp;
      drive(0, 0, 0, 1, 32'h40, 0, 0);
      n_total++; if (ctl !== CFetIdle) $display("FAIL wj_fetch act=%b exp=%b", ctl, CFetIdle); else n_pass++;
      drive(0, 0, 0, 0, 0, 0, 0);
      n_total++; if (ctl !== CWait) $display("FAIL wj_wait1 act=%b exp=%b", ctl, CWait); else n_pass++;
      drive(0, 0, 0, 0, 0, 0, 0);
      n_total++; if (ctl !== CWait) $display("FAIL wj_wait2 act=%b exp=%b", ctl, CWait); else n_pass++;
      drive(0, 0, 0, 0, 0, 0, 1);
      n_total++; if (ctl !== CWaitRed) $display("FAIL wj_ready act=%b exp=%b", ctl, CWaitRed); else n_pass++;
      n_total++; if (PC_IN !== 32'h40) $display("FAIL wj_pcin act=%h exp=%h", PC_IN, 32'h40); else n_pass++;
      drive(0, 0, 0, 0, 0, 0, 1);
      n_total++; if (ctl !== CFetAdv) $display("FAIL wj_after act=%b exp=%b", ctl, CFetAdv); else n_pass++;
      n_total++; if (pc !== 32'h40) $display("FAIL wj_pc act=%h exp=%h", pc, 32'h40); else n_pass++;
   endtask

   task automatic test_timeout;
      logic [7:0] exp_c;
      for (int k = 1; k <= 16; k++) begin
         drive(0, 0, 0, 0, 0, 0, 0);
         exp_c = (k == 1) ? CFetIdle : ((k == 16) ? CWaitErr : CWait);
         n_total++; if (ctl !== exp_c) $display("FAIL to_ctl[%0d] act=%b exp=%b", k, ctl, exp_c); else n_pass++;
      end
      drive(0, 0, 0, 0, 0, 0, 1);
      n_total++; if (ctl !== CFetRed) $display("FAIL to_redir_ctl act=%b exp=%b", ctl, CFetRed); else n_pass++;
      n_total++; if (PC_IN !== 32'h4) $display("FAIL to_redir_pcin act=%h exp=%h", PC_IN, 32'h4); else n_pass++;
      drive(0, 0, 0, 0, 0, 0, 1);
      n_total++; if (ctl !== CFetAdv) $display("FAIL to_after act=%b exp=%b", ctl, CFetAdv); else n_pass++;
      n_total++; if (pc !== 32'h4) $display("FAIL to_pc act=%h exp=%h", pc, 32'h4); else n_pass++;
   endtask

   task automatic test_stall;
      logic [31:0] pc0;
      drive(1, 0, 0, 0, 0, 0, 1);
      n_total++; if (ctl !== CFetIdle) $display("FAIL st_fetch act=%b exp=%b", ctl, CFetIdle); else n_pass++;
      pc0 = pc;
      drive(1, 1, 32'h80, 0, 0, 0, 1);
      n_total++; if (ctl !== CHold) $display("FAIL st_hold1 act=%b exp=%b", ctl, CHold); else n_pass++;
      drive(1, 0, 0, 0, 0, 0, 1);
      n_total++; if (pc !== pc0) $display("FAIL st_pc_frozen act=%h exp=%h", pc, pc0); else n_pass++;
      drive(1, 0, 0, 0, 0, 0, 1);
      n_total++; if (ctl !== CHold) $display("FAIL st_hold3 act=%b exp=%b", ctl, CHold); else n_pass++;
      drive(0, 0, 0, 0, 0, 0, 1);
      n_total++; if (ctl !== CHold) $display("FAIL st_release act=%b exp=%b", ctl, CHold); else n_pass++;
      // Pending branch outranks a live jump on the first ready cycle.
      drive(0, 0, 0, 1, 32'h200, 0, 1);
      n_total++; if (ctl !== CFetRed) $display("FAIL st_apply_ctl act=%b exp=%b", ctl, CFetRed); else n_pass++;
      n_total++; if (PC_IN !== 32'h80) $display("FAIL st_apply_pcin act=%h exp=%h", PC_IN, 32'h80); else n_pass++;
      drive(0, 0, 0, 0, 0, 0, 1);
      n_total++; if (pc !== 32'h80) $display("FAIL st_pc act=%h exp=%h", pc, 32'h80); else n_pass++;
      // Exception while stalled in FETCH.
      drive(1, 0, 0, 0, 0, 1, 1);
      n_total++; if (ctl !== CFetRed) $display("FAIL st_exc_fetch act=%b exp=%b", ctl, CFetRed); else n_pass++;
      // Exception while in HOLD.
      drive(1, 0, 0, 0, 0, 0, 1);
      drive(1, 0, 0, 0, 0, 1, 1);
      n_total++; if (ctl !== CHoldExc) $display("FAIL st_exc_hold act=%b exp=%b", ctl, CHoldExc); else n_pass++;
      n_total++; if (PC_IN !== 32'h4) $display("FAIL st_exc_pcin act=%h exp=%h", PC_IN, 32'h4); else n_pass++;
      drive(1, 0, 0, 0, 0, 0, 1);
      n_total++; if (ctl !== CFetIdle) $display("FAIL st_exc_next act=%b exp=%b", ctl, CFetIdle); else n_pass++;
      n_total++; if (pc !== 32'h4) $display("FAIL st_exc_pc act=%h exp=%h", pc, 32'h4); else n_pass++;
      drive(0, 0, 0, 0, 0, 0, 1);
      drive(0, 0, 0, 0, 0, 0, 1);
      n_total++; if (ctl !== CFetAdv) $display("FAIL st_resume act=%b exp=%b", ctl, CFetAdv); else n_pass++;
   endtask

   task automatic test_async_reset;
      drive(0, 0, 0, 1, 32'h200, 0, 0);
      drive(0, 0, 0, 0, 0, 0, 0);
      n_total++; if (ctl !== CWait) $display("FAIL ar_wait act=%b exp=%b", ctl, CWait); else n_pass++;
      #1 rst = 1'b0;
      #1;
      n_total++; if (ctl !== CBoot) $display("FAIL ar_async act=%b exp=%b", ctl, CBoot); else n_pass++;
      n_total++; if (PC_IN !== 32'h0) $display("FAIL ar_pcin act=%h exp=%h", PC_IN, 32'h0); else n_pass++;
      @(negedge clk);
      rst = 1'b1; IMEM_READY = 1'b1;
      #1;
      drive(0, 0, 0, 0, 0, 0, 1);
      n_total++; if (ctl !== CFetAdv) $display("FAIL ar_no_pend act=%b exp=%b", ctl, CFetAdv); else n_pass++;
      n_total++; if (pc !== 32'h0) $display("FAIL ar_pc0 act=%h exp=%h", pc, 32'h0); else n_pass++;
      drive(0, 0, 0, 0, 0, 0, 1);
      n_total++; if (pc !== 32'h4) $display("FAIL ar_pc4 act=%h exp=%h", pc, 32'h4); else n_pass++;
   endtask

   initial begin
      n_pass = 0; n_total = 0;
      rst = 1'b0; STALL = 1'b0; BR_TAKEN = 1'b0; BR_TARGET = 32'h0; JMP_VALID = 1'b0;
      JMP_TARGET = 32'h0; EXC_VALID = 1'b0; IMEM_READY = 1'b0;
      test_reset;
      test_seq;
      test_branch;
      test_priority;
      test_wait_jmp;
      test_timeout;
      test_stall;
      test_async_reset;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 The block SHALL have one clock, clk, and an asynchronous, active-low reset, rst.
REQ-002 Parameter RESET_VEC, default 32'h0000_0000, SHALL be the PC loaded out of reset.
REQ-003 Parameter EXC_VEC, default 32'h0000_0004, SHALL be the exception/fetch-error redirect target.
REQ-004 Parameter TIMEOUT, default 16, range 2..255, SHALL be the maximum WAIT cycles before a fetch error.
REQ-005 Ports SHALL be (name  direction  width  meaning):
 clk  in  1  clock, rising edge
 rst  in  1  async reset, active low
 STALL  in  1  hazard unit: hold fetch
 BR_TAKEN  in  1  EX-stage branch taken
 BR_TARGET  in  32  branch target
 JMP_VALID  in  1  ID-stage jump
 JMP_TARGET  in  32  jump target
 EXC_VALID  in  1  exception request
 IMEM_READY  in  1  instruction memory data valid
 PC_SRC  out  1  IF mux select: 1 = load PC_IN, 0 = PC+4
 PC_IN  out  32  redirect target to IF
 PC_EN  out  1  IF PC register write enable
 IMEM_REQ  out  1  instruction memory request
 IF_ID_EN  out  1  IF/ID register write enable
 IF_ID_FLUSH  out  1  IF/ID bubble insert
 FETCH_ERR  out  1  one-cycle fetch-timeout pulse
 STATE  out  2  current FSM state

Function
REQ-006 FSM states SHALL be BOOT=2'b00, FETCH=2'b01, WAIT=2'b10, HOLD=2'b11.
REQ-007 Redirect priority SHALL be EXC_VALID > BR_TAKEN > JMP_VALID; the selected target is EXC_VEC, BR_TARGET or JMP_TARGET, respectively.
REQ-008 The pending register (pend_v, pend_pri[1:0], pend_tgt[31:0]) SHALL capture a redirect arriving in any cycle where it is not applied; a new redirect replaces pending only if its priority is >= pend_pri.
REQ-009 Effective redirect in a cycle SHALL be the higher-priority of the live request and the pending one; on a tie, live wins.
REQ-010 BOOT: PC_SRC=1, PC_IN=RESET_VEC, PC_EN=1, IF_ID_FLUSH=1, all other outputs 0; unconditional transition to FETCH.
REQ-011 FETCH: IMEM_REQ=1; with IMEM_READY=1 and STALL=0, PC_EN=1 and IF_ID_EN=1, and the state stays FETCH.
REQ-012 The advance in REQ-011 SHALL be PC_SRC=1, PC_IN=target, IF_ID_FLUSH=1 and clear pending if a redirect is effective; otherwise PC_SRC=0 and PC_IN=32'h0.
REQ-013 FETCH with IMEM_READY=0 SHALL go to WAIT with PC_EN=0 and IF_ID_EN=0; any redirect is captured as pending.
REQ-014 FETCH or WAIT with IMEM_READY=1 and STALL=1 SHALL go to HOLD with PC_EN=0, IF_ID_EN=0 and the data discarded; redirect captured as pending.
REQ-015 EXC_VALID SHALL override STALL: it is applied as in REQ-012 even when STALL=1, and the state goes to FETCH.
REQ-016 WAIT: IMEM_REQ=1 and the PC held; IMEM_READY=1 SHALL behave as in REQ-011/012/014, with the next state FETCH or HOLD.
REQ-017 An 8-bit wait counter SHALL clear on entry to WAIT and increment each WAIT cycle.
REQ-018 When the wait counter reaches TIMEOUT-1 without IMEM_READY, the block SHALL pulse FETCH_ERR for 1 cycle, drive IMEM_REQ=0, force pending to EXC_VEC with top priority, and go to FETCH.
REQ-019 HOLD: IMEM_REQ=0, PC_EN=0, IF_ID_EN=0; STALL=0 SHALL go to FETCH, refetching the unchanged PC; redirects are captured as pending.
REQ-020 STATE SHALL equal the current state encoding.
REQ-021 PC_SRC SHALL never be 1 while PC_EN=0.

Reset
REQ-022 rst=0 SHALL immediately force state BOOT, pend_v=0, pend_pri=0, pend_tgt=0 and wait counter 0, independent of clk.
REQ-023 During reset the outputs SHALL be: PC_SRC=1, PC_IN=RESET_VEC, PC_EN=1, IF_ID_FLUSH=1, IMEM_REQ=0, IF_ID_EN=0, FETCH_ERR=0, STATE=2'b00.
REQ-024 Reset asserted mid-WAIT or mid-HOLD SHALL discard pending redirects, and fetch SHALL resume from RESET_VEC.

Verification
REQ-025 Reset release with IMEM_READY=1 held -> BOOT for 1 cycle, then FETCH; PC_SRC=0 and PC_EN=1 every cycle; the IF PC reads 0, 4, 8, ...
REQ-026 BR_TAKEN=1, BR_TARGET=32'h100 in FETCH with ready -> PC_SRC=1, PC_IN=32'h100, IF_ID_FLUSH=1 for 1 cycle.
REQ-027 BR_TAKEN=1 and JMP_VALID=1 in the same cycle (targets 32'h100 and 32'h200) -> PC_IN=32'h100.
REQ-028 JMP_VALID (target 32'h40) while IMEM_READY=0 for 3 cycles -> WAIT with PC_EN=0; on ready, PC_IN=32'h40, PC_SRC=1.
REQ-029 IMEM_READY held 0 for TIMEOUT cycles -> FETCH_ERR=1 for 1 cycle, then a redirect to 32'h0000_0004.
REQ-030 STALL=1 for 4 cycles with BR_TAKEN pulsed mid-stall -> HOLD with PC frozen; EXC_VALID during the stall redirects immediately; otherwise the branch target is applied on the first non-stall ready cycle.
